river_scheduler: RTL and testbench

Frame-rate sequencer for the river section of the playfield. On each `frame_tick` it advances every row's log positions under per-row speed dividers and wrap-around. It then serially checks the frog against every log and produces the frog's drifted x position and its on-log / in-water status. It owns the log state consumed by the renderer and the frog-position logic, and replaces ad-hoc per-cycle evaluation with a bounded, handshaked sequence.

---
 rtl/river_pkg.sv | 31 +++
 rtl/river_row_stepper.sv | 33 +++
 rtl/river_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_river_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/river_pkg.sv
// Shared types, playfield defaults and the wrap/distance arithmetic for the
// river section sequencer.
package river_pkg;

   localparam int SCREEN_W_DFLT = 320;
   localparam int TILE_DFLT     = 32;
   localparam int LOG_W_DFLT    = 64;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADVANCE,
      S_CHECK,
      S_COMMIT
   } state_t;

   function automatic logic [9:0] wrap_step(input logic [9:0] x,
                                            input logic       dir,
                                            input logic [9:0] w);
      if (dir) return (x == w - 10'd1) ? 10'd0 : x + 10'd1;
      else     return (x == 10'd0) ? w - 10'd1 : x - 10'd1;
   endfunction

   // (a - b) mod w, widened so the wrap-around sum cannot overflow
   function automatic logic [10:0] mod_dist(input logic [9:0] a,
                                            input logic [9:0] b,
                                            input logic [9:0] w);
      if (a >= b) return {1'b0, a} - {1'b0, b};
      else        return {1'b0, a} + {1'b0, w} - {1'b0, b};
   endfunction

endpackage

// File: rtl/river_row_stepper.sv
// Frame divider and log stepping for a single river row; the scheduler
// time-shares one instance across rows.
module river_row_stepper
   import river_pkg::*;
#(
   parameter int NUM_LOGS = 2,
   parameter int SCREEN_W = SCREEN_W_DFLT
) (
   input  logic [3:0]             period,
   input  logic [3:0]             div,
   input  logic                   dir,
   input  logic [NUM_LOGS*10-1:0] pos,
   output logic [3:0]             div_next,
   output logic                   step,
   output logic [NUM_LOGS*10-1:0] pos_next
);

   always_comb begin
      div_next = 4'd0;
      step     = 1'b0;
      pos_next = pos;
      if (period != 4'd0) begin
         if (div == period - 4'd1) begin
            step = 1'b1;
            for (int k = 0; k < NUM_LOGS; k++)
               pos_next[k*10 +: 10] = wrap_step(pos[k*10 +: 10], dir, 10'(SCREEN_W));
         end else begin
            div_next = div + 4'd1;
         end
      end
   end

endmodule

// File: rtl/river_scheduler.sv
// Per-frame river sequencer: steps every row's logs, then scans the frog
// against each log serially and commits drift / on-log / in-water results.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   S_IDLE    | waiting for frame_tick
//   S_ADVANCE | one row per cycle: divider update and log step
//   S_CHECK   | one (row, log) pair per cycle, row-major overlap scan
//   S_COMMIT  | register frog results, pulse done
module river_scheduler
   import river_pkg::*;
#(
   parameter int NUM_ROWS = 4,
   parameter int NUM_LOGS = 2,
   parameter int SCREEN_W = SCREEN_W_DFLT,
   parameter int TILE     = TILE_DFLT,
   parameter int LOG_W    = LOG_W_DFLT
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           frame_tick,
   input  logic [9:0]                     frog_x,
   input  logic [9:0]                     frog_y,
   input  logic [NUM_ROWS*10-1:0]         river_y,
   input  logic [NUM_ROWS*4-1:0]          row_period,
   input  logic [NUM_ROWS-1:0]            row_dir,
   output logic [NUM_ROWS*NUM_LOGS*10-1:0] log_x,
   output logic [9:0]                     frog_x_new,
   output logic                           frog_on_log,
   output logic                           frog_in_water,
   output logic                           busy,
   output logic                           done,
   output logic                           overrun
);

   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int KW = (NUM_LOGS > 1) ? $clog2(NUM_LOGS) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
   localparam logic [KW-1:0] LAST_LOG = KW'(NUM_LOGS - 1);
   localparam logic [9:0]    X_MAX    = 10'(SCREEN_W - TILE);

   state_t state, state_nx;

   logic [9:0]          fx_q, fy_q;
   logic [RW-1:0]       row_idx;
   logic [KW-1:0]       log_idx;
   logic [3:0]          div_q [NUM_ROWS];
   logic [NUM_ROWS-1:0] moved;
   logic [9:0]          pos_q [NUM_ROWS][NUM_LOGS];
   logic                hit_valid;
   logic [RW-1:0]       hit_row;
   logic                on_hit;

   logic [9:0]             ry  [NUM_ROWS];
   logic [3:0]             per [NUM_ROWS];
   logic [NUM_LOGS*10-1:0] row_pos, row_pos_nx;
   logic [3:0]             div_nx;
   logic                   step;
   logic                   row_match, overlap, take;
   logic [9:0]             drift_x;

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      assign ry[r]  = river_y[r*10 +: 10];
      assign per[r] = row_period[r*4 +: 4];
      for (genvar k = 0; k < NUM_LOGS; k++) begin : g_log
         assign log_x[(r*NUM_LOGS + k)*10 +: 10] = pos_q[r][k];
      end
   end

   always_comb begin
      row_pos = '0;
      for (int k = 0; k < NUM_LOGS; k++)
         row_pos[k*10 +: 10] = pos_q[row_idx][k];
   end

   river_row_stepper #(
      .NUM_LOGS (NUM_LOGS),
      .SCREEN_W (SCREEN_W)
   ) u_stepper (
      .period   (per[row_idx]),
      .div      (div_q[row_idx]),
      .dir      (row_dir[row_idx]),
      .pos      (row_pos),
      .div_next (div_nx),
      .step     (step),
      .pos_next (row_pos_nx)
   );

   // only the first matching row is scanned; later rows with the same y are ignored
   assign row_match = (fy_q == ry[row_idx]);
   assign overlap   = mod_dist(fx_q, pos_q[row_idx][log_idx], 10'(SCREEN_W)) < 11'(LOG_W);
   assign take      = row_match && (!hit_valid || hit_row == row_idx);

   always_comb begin
      drift_x = fx_q;
      if (moved[hit_row]) begin
         if (row_dir[hit_row]) drift_x = (fx_q >= X_MAX) ? X_MAX : fx_q + 10'd1;
         else                  drift_x = (fx_q == 10'd0) ? 10'd0 : fx_q - 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (frame_tick) state_nx = S_ADVANCE;
         S_ADVANCE: if (row_idx == LAST_ROW) state_nx = S_CHECK;
         S_CHECK:   if (row_idx == LAST_ROW && log_idx == LAST_LOG) state_nx = S_COMMIT;
         S_COMMIT:  state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fx_q          <= '0;
         fy_q          <= '0;
         row_idx       <= '0;
         log_idx       <= '0;
         moved         <= '0;
         hit_valid     <= 1'b0;
         hit_row       <= '0;
         on_hit        <= 1'b0;
         frog_x_new    <= '0;
         frog_on_log   <= 1'b0;
         frog_in_water <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overrun       <= 1'b0;
         for (int r = 0; r < NUM_ROWS; r++) begin
            div_q[r] <= '0;
            for (int k = 0; k < NUM_LOGS; k++)
               pos_q[r][k] <= 10'(k * (SCREEN_W / NUM_LOGS));
         end
      end else begin
         done <= 1'b0;
         if (frame_tick && state != S_IDLE) overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               if (frame_tick) begin
                  fx_q      <= frog_x;
                  fy_q      <= frog_y;
                  row_idx   <= '0;
                  log_idx   <= '0;
                  hit_valid <= 1'b0;
                  hit_row   <= '0;
                  on_hit    <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_ADVANCE: begin
               div_q[row_idx] <= div_nx;
               moved[row_idx] <= step;
               for (int k = 0; k < NUM_LOGS; k++)
                  pos_q[row_idx][k] <= row_pos_nx[k*10 +: 10];
               row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + RW'(1);
            end
            S_CHECK: begin
               if (take) begin
                  hit_valid <= 1'b1;
                  hit_row   <= row_idx;
                  if (overlap) on_hit <= 1'b1;
               end
               if (log_idx == LAST_LOG) begin
                  log_idx <= '0;
                  row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + RW'(1);
               end else begin
                  log_idx <= log_idx + KW'(1);
               end
            end
            S_COMMIT: begin
               busy          <= 1'b0;
               done          <= 1'b1;
               frog_on_log   <= hit_valid && on_hit;
               frog_in_water <= hit_valid && !on_hit;
               frog_x_new    <= (hit_valid && on_hit) ? drift_x : fx_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_river_scheduler.sv
// Scoreboarded bench for river_scheduler: directed scenarios plus random
// frames, checked against a frame-level model of log motion and frog status.
module tb_river_scheduler;

   localparam int NR   = 4;
   localparam int NL   = 2;
   localparam int W    = 320;
   localparam int TILE = 32;
   localparam int LW   = 64;

   logic                clk = 1'b0;
   logic                reset_n, frame_tick;
   logic [9:0]          frog_x, frog_y;
   logic [NR*10-1:0]    river_y;
   logic [NR*4-1:0]     row_period;
   logic [NR-1:0]       row_dir;
   logic [NR*NL*10-1:0] log_x;
   logic [9:0]          frog_x_new;
   logic                frog_on_log, frog_in_water, busy, done, overrun;

   river_scheduler dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .frame_tick    (frame_tick),
      .frog_x        (frog_x),
      .frog_y        (frog_y),
      .river_y       (river_y),
      .row_period    (row_period),
      .row_dir       (row_dir),
      .log_x         (log_x),
      .frog_x_new    (frog_x_new),
      .frog_on_log   (frog_on_log),
      .frog_in_water (frog_in_water),
      .busy          (busy),
      .done          (done),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [9:0] ry  [NR];
   logic [3:0] per [NR];
   logic       dir [NR];

   always_comb begin
      river_y    = '0;
      row_period = '0;
      row_dir    = '0;
      for (int r = 0; r < NR; r++) begin
         river_y[r*10 +: 10] = ry[r];
         row_period[r*4 +: 4] = per[r];
         row_dir[r]           = dir[r];
      end
   end

   typedef struct {
      int                  cyc;
      logic [9:0]          x;
      logic                on;
      logic                water;
      logic [NR*NL*10-1:0] lx;
   } exp_t;

   exp_t sb [$];
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;

   int mlog [NR][NL];
   int mdiv [NR];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [9:0] lx(input int r, input int k);
      return log_x[(r*NL + k)*10 +: 10];
   endfunction

   function automatic logic [NR*NL*10-1:0] model_logs();
      logic [NR*NL*10-1:0] v = '0;
      for (int r = 0; r < NR; r++)
         for (int k = 0; k < NL; k++)
            v[(r*NL + k)*10 +: 10] = 10'(mlog[r][k]);
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NR; r++) begin
         mdiv[r] = 0;
         for (int k = 0; k < NL; k++) mlog[r][k] = k * (W / NL);
      end
   endtask

   // one frame: move rows by their dividers, then classify the frog
   task automatic model_tick(input int fx, input int fy, input int tcyc);
      bit   mv [NR];
      int   hit = -1;
      bit   on  = 0;
      exp_t e;
      for (int r = 0; r < NR; r++) begin
         mv[r] = 0;
         if (per[r] == 0) mdiv[r] = 0;
         else if (mdiv[r] == int'(per[r]) - 1) begin
            mdiv[r] = 0;
            mv[r]   = 1;
            for (int k = 0; k < NL; k++)
               mlog[r][k] = dir[r] ? (mlog[r][k] + 1) % W : (mlog[r][k] + W - 1) % W;
         end else mdiv[r] = (mdiv[r] + 1) % 16;
      end
      for (int r = 0; r < NR; r++)
         if (hit < 0 && fy == int'(ry[r])) hit = r;
      if (hit >= 0)
         for (int k = 0; k < NL; k++)
            if ((((fx - mlog[hit][k]) % W) + W) % W < LW) on = 1;
      e.x = 10'(fx); e.on = 0; e.water = 0;
      if (hit >= 0) begin
         if (on) begin
            e.on = 1;
            if (mv[hit]) begin
               if (dir[hit]) e.x = 10'((fx + 1 > W - TILE) ? W - TILE : fx + 1);
               else          e.x = 10'((fx - 1 < 0) ? 0 : fx - 1);
            end
         end else e.water = 1;
      end
      e.cyc = tcyc + 13;
      e.lx  = model_logs();
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset_n && done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done at cycle %0d required=no done", cyc);
         end else begin
            e = sb.pop_front();
            chk("done_cycle", 80'(cyc), 80'(e.cyc));
            chk("frog_x_new", 80'(frog_x_new), 80'(e.x));
            chk("frog_on_log", 80'(frog_on_log), 80'(e.on));
            chk("frog_in_water", 80'(frog_in_water), 80'(e.water));
            chk("log_x", 80'(log_x), 80'(e.lx));
            chk("busy_at_done", 80'(busy), 80'(0));
         end
      end
   end

   task automatic tick(input int fx, input int fy, input bit expect_seq);
      frog_x     = 10'(fx);
      frog_y     = 10'(fy);
      frame_tick = 1'b1;
      if (expect_seq) model_tick(fx, fy, cyc + 1);
      @(posedge clk);
      #1 frame_tick = 1'b0;
   endtask

   // returns at the negedge where done is high, so the next tick lands on the done cycle
   task automatic run_tick(input int fx, input int fy);
      int n = 0;
      tick(fx, fy, 1);
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL done_timeout actual=no done after %0d cycles required=done", n);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 80'(busy), 80'(0));
      chk({tag, "_done"}, 80'(done), 80'(0));
      chk({tag, "_overrun"}, 80'(overrun), 80'(0));
      chk({tag, "_frog_x_new"}, 80'(frog_x_new), 80'(0));
      chk({tag, "_flags"}, 80'({frog_on_log, frog_in_water}), 80'(0));
      chk({tag, "_log_x"}, 80'(log_x), 80'(model_logs()));
   endtask

   initial begin
      int start;
      reset_n    = 1'b0;
      frame_tick = 1'b0;
      frog_x     = '0;
      frog_y     = '0;
      ry[0] = 10'd100; ry[1] = 10'd150; ry[2] = 10'd200; ry[3] = 10'd250;
      for (int r = 0; r < NR; r++) begin per[r] = 4'd0; dir[r] = 1'b0; end
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check_reset_vals("reset");
      chk("reset_log01", 80'(lx(0, 1)), 80'(160));

      per[0] = 4'd1; dir[0] = 1'b1;
      run_tick(50, 999);
      chk("t1_log00", 80'(lx(0, 0)), 80'(1));
      chk("t1_log01", 80'(lx(0, 1)), 80'(161));
      chk("t1_log10", 80'(lx(1, 0)), 80'(0));

      per[0] = 4'd0; per[1] = 4'd1; dir[1] = 1'b0;
      run_tick(50, 999);
      chk("left_wrap", 80'(lx(1, 0)), 80'(319));
      dir[1] = 1'b1;
      run_tick(50, 999);
      chk("right_wrap", 80'(lx(1, 0)), 80'(0));
      per[1] = 4'd0;

      per[2] = 4'd3; dir[2] = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         run_tick(50, 999);
         chk($sformatf("divider_tick%0d", i), 80'(lx(2, 0)), 80'(i / 3));
      end

      per[2] = 4'd1;
      run_tick(13, 200);
      chk("onlog_flag", 80'(frog_on_log), 80'(1));
      chk("onlog_drift", 80'(frog_x_new), 80'(14));
      per[2] = 4'd0;

      per[3] = 4'd1; dir[3] = 1'b0;
      for (int i = 0; i < 19; i++) run_tick(50, 999);
      run_tick(10, 250);
      chk("seam_log30", 80'(lx(3, 0)), 80'(300));
      chk("seam_onlog", 80'(frog_on_log), 80'(1));
      chk("seam_drift", 80'(frog_x_new), 80'(9));
      per[3] = 4'd0;
      run_tick(60, 250);
      chk("seam_water", 80'(frog_in_water), 80'(1));
      chk("seam_water_x", 80'(frog_x_new), 80'(60));
      per[3] = 4'd1;
      run_tick(0, 250);
      chk("left_saturate", 80'(frog_x_new), 80'(0));

      chk("overrun_before", 80'(overrun), 80'(0));
      tick(40, 999, 1);
      start = done_cnt;
      chk("busy_mid", 80'(busy), 80'(1));
      repeat (4) @(posedge clk);
      #1 tick(40, 999, 0);
      repeat (30) @(negedge clk);
      chk("overrun_set", 80'(overrun), 80'(1));
      chk("overrun_single_done", 80'(done_cnt), 80'(start + 1));

      tick(40, 999, 1);
      start = done_cnt;
      repeat (7) @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      sb.delete();
      model_reset();
      repeat (25) @(negedge clk);
      chk("abort_no_done", 80'(done_cnt), 80'(start));
      check_reset_vals("abort");

      for (int i = 0; i < 40; i++) begin
         int r, fx, fy;
         for (int q = 0; q < NR; q++) begin
            per[q] = 4'($urandom_range(0, 3));
            dir[q] = 1'($urandom_range(0, 1));
            ry[q]  = 10'($urandom_range(0, 1023));
         end
         r  = $urandom_range(0, NR - 1);
         fy = ($urandom_range(0, 9) < 7) ? int'(ry[r]) : $urandom_range(0, 1023);
         fx = mlog[r][$urandom_range(0, NL - 1)] + $urandom_range(0, 90) - 10;
         fx = ((fx % W) + W) % W;
         if (fx > W - TILE) fx = W - TILE;
         run_tick(fx, fy);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 80'(sb.size()), 80'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
